// File: rtl/reg_file_pkg.sv
// Shared defaults and the bypass-resolution helper for the multi-port register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 3;

  // Helper operates on the widest supported shape; callers zero-extend in and truncate out.
  localparam int MAX_DATA_W = 64;
  localparam int MAX_ADDR_W = 16;

  function automatic logic [MAX_DATA_W-1:0] bypass_data(
    input logic [MAX_ADDR_W-1:0] ra,
    input logic                  we0,
    input logic [MAX_ADDR_W-1:0] wa0,
    input logic [MAX_DATA_W-1:0] wd0,
    input logic                  we1,
    input logic [MAX_ADDR_W-1:0] wa1,
    input logic [MAX_DATA_W-1:0] wd1,
    input logic [MAX_DATA_W-1:0] stored
  );
    logic [MAX_DATA_W-1:0] res;
    if (we1 && (wa1 == ra)) begin
      res = wd1;
    end else if (we0 && (wa0 == ra)) begin
      res = wd0;
    end else begin
      res = stored;
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write ports, packed read ports, issue and scoreboard status.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD
);

  logic                     we0;
  logic [ADDR_W-1:0]        wa0;
  logic [DATA_W-1:0]        wd0;
  logic                     we1;
  logic [ADDR_W-1:0]        wa1;
  logic [DATA_W-1:0]        wd1;
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rpend;
  logic                     iss_v;
  logic [ADDR_W-1:0]        iss_a;
  logic [ADDR_W:0]          pend_cnt;

  modport master (
    output we0, wa0, wd0, we1, wa1, wd1, ra, iss_v, iss_a,
    input  rd, rpend, pend_cnt
  );

  modport slave (
    input  we0, wa0, wd0, we1, wa1, wd1, ra, iss_v, iss_a,
    output rd, rpend, pend_cnt
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Pending-bit scoreboard: issue sets, writes clear, with an incrementally maintained population count.
module reg_scoreboard #(
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clr0,
  input  logic [ADDR_W-1:0]        i_ca0,
  input  logic                     i_clr1,
  input  logic [ADDR_W-1:0]        i_ca1,
  input  logic                     i_set,
  input  logic [ADDR_W-1:0]        i_sa,
  input  logic [NUM_RD*ADDR_W-1:0] i_ra,
  output logic [NUM_RD-1:0]        o_rpend,
  output logic [ADDR_W:0]          o_pend_cnt
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DEPTH-1:0] r_pend;
  logic [ADDR_W:0]  r_cnt;
  logic [ADDR_W:0]  w_inc;
  logic [ADDR_W:0]  w_dec0;
  logic [ADDR_W:0]  w_dec1;
  logic             w_hit0;
  logic             w_hit1;

  // A cleared entry that is also being set stays pending, so it never counts as a decrement;
  // both write ports hitting the same entry count as one clear.
  assign w_hit0 = i_clr0 && r_pend[i_ca0] && !(i_set && (i_ca0 == i_sa));
  assign w_hit1 = i_clr1 && r_pend[i_ca1] && !(i_set && (i_ca1 == i_sa))
                  && !(i_clr0 && (i_ca0 == i_ca1));
  assign w_inc  = {{ADDR_W{1'b0}}, (i_set && !r_pend[i_sa])};
  assign w_dec0 = {{ADDR_W{1'b0}}, w_hit0};
  assign w_dec1 = {{ADDR_W{1'b0}}, w_hit1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend <= {DEPTH{1'b0}};
      r_cnt  <= {(ADDR_W+1){1'b0}};
    end else begin
      if (i_clr0) begin
        r_pend[i_ca0] <= 1'b0;
      end
      if (i_clr1) begin
        r_pend[i_ca1] <= 1'b0;
      end
      if (i_set) begin
        r_pend[i_sa] <= 1'b1;
      end
      r_cnt <= r_cnt + w_inc - w_dec0 - w_dec1;
    end
  end

  // Same-cycle writes mask the pending bit; the same-cycle issue does not show up until the edge.
  always_comb begin
    o_rpend = {NUM_RD{1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      o_rpend[k] = r_pend[i_ra[k*ADDR_W +: ADDR_W]]
                   && !(i_clr0 && (i_ca0 == i_ra[k*ADDR_W +: ADDR_W]))
                   && !(i_clr1 && (i_ca1 == i_ra[k*ADDR_W +: ADDR_W]));
    end
  end

  assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, multi-read register file with same-cycle write bypass and an issue scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input logic           clk,
  input logic           reset,
  reg_file_mp_if.slave  bus
);

  localparam int DEPTH = 32'sd1 << ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic                     w_we0;
  logic                     w_we1;
  logic                     w_iss;
  logic [NUM_RD*DATA_W-1:0] w_rd;

  function automatic logic writable(input logic [ADDR_W-1:0] a);
    return !((ZERO_REG != 32'sd0) && (a == {ADDR_W{1'b0}}));
  endfunction

  // Effective enables: entry 0 is inert when hardwired, and nothing acts while reset is held.
  assign w_we0 = !reset && bus.we0 && writable(bus.wa0);
  assign w_we1 = !reset && bus.we1 && writable(bus.wa1);
  assign w_iss = !reset && bus.iss_v && writable(bus.iss_a);

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {DATA_W{1'b0}};
      end
    end else begin
      if (w_we0) begin
        r_mem[bus.wa0] <= bus.wd0;
      end
      if (w_we1) begin
        r_mem[bus.wa1] <= bus.wd1;
      end
    end
  end

  always_comb begin
    w_rd = {(NUM_RD*DATA_W){1'b0}};
    for (int k = 0; k < NUM_RD; k++) begin
      if (reset) begin
        w_rd[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end else begin
        w_rd[k*DATA_W +: DATA_W] = DATA_W'(bypass_data(
          MAX_ADDR_W'(bus.ra[k*ADDR_W +: ADDR_W]),
          w_we0, MAX_ADDR_W'(bus.wa0), MAX_DATA_W'(bus.wd0),
          w_we1, MAX_ADDR_W'(bus.wa1), MAX_DATA_W'(bus.wd1),
          MAX_DATA_W'(r_mem[bus.ra[k*ADDR_W +: ADDR_W]])));
      end
    end
  end

  assign bus.rd = w_rd;

  reg_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .i_clr0     (w_we0),
    .i_ca0      (bus.wa0),
    .i_clr1     (w_we1),
    .i_ca1      (bus.wa1),
    .i_set      (w_iss),
    .i_sa       (bus.iss_a),
    .i_ra       (bus.ra),
    .o_rpend    (bus.rpend),
    .o_pend_cnt (bus.pend_cnt)
  );

endmodule
